dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported data memory.
- Requester 0 is the CPU load/store unit. Requester 1 is the debug/loader port (UART bootloader, hex patching).
- Converts each granted request into a one-cycle memread/memwrite command pulse and tracks the memory's clk_stall busy indication.
- Returns read data with a one-cycle ack per transaction, and exposes a stall output the CPU uses to freeze its pipeline.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for each clk_stall edge before aborting with err.
- CPU_BURST, 4: maximum consecutive CPU grants while requester 1 is pending; 0 means strict round-robin.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- r0_read  in  1  CPU read request, level, held until r0_ack
- r0_write  in  1  CPU write request, level, held until r0_ack
- r0_addr  in  32  CPU byte address
- r0_wdata  in  32  CPU write data
- r0_sign_mask  in  4  CPU size/sign encoding, passed through unchanged
- r0_rdata  out  32  CPU read data, valid with r0_ack
- r0_ack  out  1  one-cycle completion pulse
- r0_stall  out  1  high from CPU request acceptance until r0_ack inclusive; combinational with r0_read|r0_write while not yet granted
- r1_read, r1_write, r1_addr, r1_wdata, r1_sign_mask, r1_rdata, r1_ack  as for r0 but for the debug port
- err  out  1  one-cycle pulse coincident with ack when the transaction timed out
- mem_addr  out  32  to data memory addr
- mem_write_data  out  32  to data memory write_data
- mem_memread  out  1  to data memory memread
- mem_memwrite  out  1  to data memory memwrite
- mem_sign_mask  out  4  to data memory sign_mask
- mem_read_data  in  32  from data memory read_data
- mem_clk_stall  in  1  from data memory clk_stall

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE.
  - All outputs 0, except r0_stall, which follows its combinational term.
  - Burst counter 0; last-grant register = 1, so the CPU wins the first tie.
  - Reset mid-transaction abandons it with no ack. A memory left in a stall state finishes on its own; the arbiter issues nothing until mem_clk_stall is seen low in IDLE.
- All mem_* outputs are registered. Command lines are 0 in every state except ISSUE.
- IDLE:
  - If mem_clk_stall=0 and any request is pending, select a winner:
    - Only one requester pending: it wins.
    - Both pending: the requester other than last-grant wins.
    - Exception: the CPU wins if the last grant was CPU and burst count < CPU_BURST.
  - Latch the winner's addr/wdata/sign_mask/read/write into mem_*. Go to ISSUE.
  - read and write both high: treat as read.
- ISSUE (1 cycle): mem_memread or mem_memwrite = 1. Next state WAIT_HI; the timeout counter clears.
- WAIT_HI: wait for mem_clk_stall=1, then go to WAIT_LO and clear the counter.
- WAIT_LO: wait for mem_clk_stall=0, then go to RESP.
- RESP (1 cycle):
  - Winner's ack=1. For reads, rdata is captured from mem_read_data in this cycle and held until the next ack for that port.
  - Update last-grant. Burst count increments on a CPU grant while requester 1 is pending; otherwise it is 0.
  - Return to IDLE.
- Timeout: the counter reaching TIMEOUT in WAIT_HI or WAIT_LO forces RESP with err=1; rdata is not updated.
- Latency with nominal memory (stall rises 1 cycle after the command, falls 2 cycles later): request seen in IDLE at cycle 0, ISSUE at 1, ack at 5. Minimum request-to-request spacing is 6 cycles.
- Requests must stay stable until ack. A request dropped before grant is simply not served. A request dropped after grant still completes and still acks.
- Non-winning port: ack=0; its stall stays high while its request is pending.
- Address 0x2000 LED writes pass through like any other write.

Decomposition:
- Shared package dmem_pkg holds:
  - State encoding constants: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
  - Requester index constants: REQ_CPU=0, REQ_DBG=1.
  - sign_mask field positions.
- One natural sub-module, rr_grant2: the two-way grant decision, last-grant register and burst counter. The FSM and datapath stay in the top.

Test Plan:
- Single CPU read: memory model holds 0xDEADBEEF at 0x1000 with the nominal stall profile; r0_read with r0_addr=0x1000 -> mem_memread high for exactly 1 cycle; r0_ack 5 cycles after request; r0_rdata=0xDEADBEEF; r1_ack never pulses.
- Simultaneous requests from reset: r0 writes 0x11 to 0x1004 and r1 reads 0x1008 -> CPU granted first; debug acked next; the two commands are at least 6 cycles apart.
- CPU_BURST=4 fairness: CPU requests back-to-back continuously with r1_read held -> exactly 4 CPU acks, then 1 debug ack, repeating.
- Timeout: mem_clk_stall held 0 after ISSUE -> after 16 WAIT_HI cycles, ack and err pulse together and r0_rdata is unchanged; the next request proceeds normally.
- Reset mid-transaction: rst_n=0 during WAIT_LO -> all mem_* outputs 0 and no ack. After release with stall still high, nothing is issued until stall falls, then the pending request is served.
- Read and write asserted together on r1 -> mem_memread=1, mem_memwrite=0; read data returned with r1_ack.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester
// indices and the layout of the sign_mask code forwarded to the memory.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // sign_mask layout as the data memory decodes it; the arbiter forwards it opaquely.
  localparam int SM_SIZE_LSB  = 0;
  localparam int SM_SIZE_MSB  = 1;
  localparam int SM_SIGN_BIT  = 2;
  localparam int SM_SPARE_BIT = 3;
  localparam int SM_W         = SM_SPARE_BIT + 1;

  // A requester is pending when either command line is raised.
  function automatic logic req_pending(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Two-way grant decision with a bounded CPU burst while the debug port waits.
module rr_grant2
  import dmem_pkg::*;
#(
  parameter int CPU_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic grant_idx,
  output logic winner
);

  localparam int BW = $clog2(CPU_BURST + 2);

  logic          last_r;
  logic [BW-1:0] burst_r;
  logic          cpu_keep_s;

  // Pick the winner from the current requests, last grant and burst count.
  always_comb begin
    cpu_keep_s = (last_r == REQ_CPU) && (burst_r < BW'(CPU_BURST));
    if (req0 && !req1) begin
      winner = REQ_CPU;
    end else if (!req0 && req1) begin
      winner = REQ_DBG;
    end else if (req0 && req1) begin
      if (cpu_keep_s) begin
        winner = REQ_CPU;
      end else begin
        winner = ~last_r;
      end
    end else begin
      winner = REQ_CPU;
    end
  end

  // Record the completed grant; count CPU grants made while debug was waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r  <= REQ_DBG;
      burst_r <= '0;
    end else if (update) begin
      last_r <= grant_idx;
      if ((grant_idx == REQ_CPU) && req1) begin
        if (burst_r != {BW{1'b1}}) begin
          burst_r <= burst_r + 1'b1;
        end
      end else begin
        burst_r <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer between the CPU load/store unit, the debug loader port
// and the single-ported data memory with its clk_stall handshake.
module dmem_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int CPU_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_read,
  input  logic        r0_write,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_sign_mask,
  output logic [31:0] r0_rdata,
  output logic        r0_ack,
  output logic        r0_stall,
  input  logic        r1_read,
  input  logic        r1_write,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_sign_mask,
  output logic [31:0] r1_rdata,
  output logic        r1_ack,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);
  import dmem_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_r;
  logic            grant_r;
  logic            op_rd_r;
  logic [TW-1:0]   tmo_r;
  logic [31:0]     mem_addr_r, mem_wdata_r, r0_rdata_r, r1_rdata_r;
  logic [SM_W-1:0] mem_mask_r;
  logic            mem_memread_r, mem_memwrite_r;
  logic            r0_ack_r, r1_ack_r, err_r;

  logic            req0_s, req1_s, winner_s, update_s, tmo_last_s;
  logic            win_rd_s, win_wr_s;
  logic [31:0]     win_addr_s, win_wdata_s;
  logic [SM_W-1:0] win_mask_s;

  rr_grant2 #(.CPU_BURST(CPU_BURST)) u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0_s),
    .req1      (req1_s),
    .update    (update_s),
    .grant_idx (grant_r),
    .winner    (winner_s)
  );

  // Request decode and winner operand mux; read wins over write on one port.
  always_comb begin
    req0_s     = req_pending(r0_read, r0_write);
    req1_s     = req_pending(r1_read, r1_write);
    update_s   = (state_r == RESP);
    tmo_last_s = (tmo_r == TW'(TIMEOUT - 1));
    if (winner_s == REQ_CPU) begin
      win_rd_s    = r0_read;
      win_wr_s    = r0_write & ~r0_read;
      win_addr_s  = r0_addr;
      win_wdata_s = r0_wdata;
      win_mask_s  = r0_sign_mask;
    end else begin
      win_rd_s    = r1_read;
      win_wr_s    = r1_write & ~r1_read;
      win_addr_s  = r1_addr;
      win_wdata_s = r1_wdata;
      win_mask_s  = r1_sign_mask;
    end
  end

  // Sequencer: grant, one-cycle command, clk_stall tracking with timeout, response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      grant_r        <= REQ_CPU;
      op_rd_r        <= 1'b0;
      tmo_r          <= '0;
      mem_addr_r     <= 32'h0;
      mem_wdata_r    <= 32'h0;
      mem_mask_r     <= '0;
      mem_memread_r  <= 1'b0;
      mem_memwrite_r <= 1'b0;
      r0_rdata_r     <= 32'h0;
      r1_rdata_r     <= 32'h0;
      r0_ack_r       <= 1'b0;
      r1_ack_r       <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      mem_memread_r  <= 1'b0;
      mem_memwrite_r <= 1'b0;
      r0_ack_r       <= 1'b0;
      r1_ack_r       <= 1'b0;
      err_r          <= 1'b0;
      case (state_r)
        IDLE: begin
          // A memory still busy from before a reset must drain first.
          if (!mem_clk_stall && (req0_s || req1_s)) begin
            grant_r        <= winner_s;
            op_rd_r        <= win_rd_s;
            mem_addr_r     <= win_addr_s;
            mem_wdata_r    <= win_wdata_s;
            mem_mask_r     <= win_mask_s;
            mem_memread_r  <= win_rd_s;
            mem_memwrite_r <= win_wr_s;
            state_r        <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_r   <= '0;
          state_r <= WAIT_HI;
        end
        WAIT_HI: begin
          if (mem_clk_stall) begin
            tmo_r   <= '0;
            state_r <= WAIT_LO;
          end else if (tmo_last_s) begin
            err_r    <= 1'b1;
            r0_ack_r <= (grant_r == REQ_CPU);
            r1_ack_r <= (grant_r == REQ_DBG);
            state_r  <= RESP;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!mem_clk_stall) begin
            r0_ack_r <= (grant_r == REQ_CPU);
            r1_ack_r <= (grant_r == REQ_DBG);
            if (op_rd_r && (grant_r == REQ_CPU)) begin
              r0_rdata_r <= mem_read_data;
            end
            if (op_rd_r && (grant_r == REQ_DBG)) begin
              r1_rdata_r <= mem_read_data;
            end
            state_r <= RESP;
          end else if (tmo_last_s) begin
            err_r    <= 1'b1;
            r0_ack_r <= (grant_r == REQ_CPU);
            r1_ack_r <= (grant_r == REQ_DBG);
            state_r  <= RESP;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // CPU freezes while its request waits for a grant and until its ack.
  assign r0_stall       = req0_s | ((state_r != IDLE) && (grant_r == REQ_CPU));
  assign r0_rdata       = r0_rdata_r;
  assign r0_ack         = r0_ack_r;
  assign r1_rdata       = r1_rdata_r;
  assign r1_ack         = r1_ack_r;
  assign err            = err_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_wdata_r;
  assign mem_memread    = mem_memread_r;
  assign mem_memwrite   = mem_memwrite_r;
  assign mem_sign_mask  = mem_mask_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a nominal-stall memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk, rst_n;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_sign_mask, r1_sign_mask;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        r0_ack, r0_stall, r1_ack, err, mem_memread, mem_memwrite, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  dmem_arbiter #(.TIMEOUT(16), .CPU_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_sign_mask(r0_sign_mask), .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_stall(r0_stall),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_sign_mask(r1_sign_mask), .r1_rdata(r1_rdata), .r1_ack(r1_ack), .err(err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: stall rises the cycle after a command, stays 2 cycles, data valid as it falls.
  logic [31:0] mem_model [0:4095];
  logic        mm_init = 1'b0;
  logic        mm_stall, mm_rd, mm_en, stall_force;
  int          mm_cnt;
  logic [11:0] mm_idx;
  logic [31:0] mm_rdata;

  assign mem_clk_stall = mm_stall | stall_force;
  assign mem_read_data = mm_rdata;

  always @(posedge clk) begin
    if (!mm_init) begin
      for (int i = 0; i < 4096; i++) mem_model[i] <= 32'h0;
      mem_model[12'h400] <= 32'hDEADBEEF;
      mm_init <= 1'b1; mm_stall <= 1'b0; mm_cnt <= 0; mm_rd <= 1'b0;
      mm_idx <= 12'h0; mm_rdata <= 32'h0;
    end else if (mem_memread || mem_memwrite) begin
      if (mem_memwrite) mem_model[mem_addr[13:2]] <= mem_write_data;
      mm_rd  <= mem_memread;
      mm_idx <= mem_addr[13:2];
      if (mm_en) begin
        mm_stall <= 1'b1;
        mm_cnt   <= 1;
      end
    end else if (mm_stall) begin
      if (mm_cnt > 0) begin
        mm_cnt <= mm_cnt - 1;
      end else begin
        mm_stall <= 1'b0;
        if (mm_rd) mm_rdata <= mem_model[mm_idx];
      end
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Per-run event log, cycle k = k-th cycle after the edge that first sees the request.
  int cmd_q[$], a0_q[$], a1_q[$], err_q[$], ord_q[$];
  logic        cmd_rd_c, cmd_wr_c, stall_at_ack_c;
  logic [31:0] cmd_addr_c, cmd_wdata_c, ack_rdata_c;
  logic [3:0]  cmd_mask_c;
  bit          drop0, drop1;

  task automatic run_log(input int n);
    cmd_q.delete(); a0_q.delete(); a1_q.delete(); err_q.delete(); ord_q.delete();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        if (cmd_q.size() == 0) begin
          cmd_rd_c = mem_memread; cmd_wr_c = mem_memwrite; cmd_addr_c = mem_addr;
          cmd_wdata_c = mem_write_data; cmd_mask_c = mem_sign_mask;
        end
        cmd_q.push_back(k);
      end
      if (err) err_q.push_back(k);
      if (r0_ack) begin
        a0_q.push_back(k); ord_q.push_back(0);
        ack_rdata_c = r0_rdata; stall_at_ack_c = r0_stall;
        if (drop0) begin r0_read = 1'b0; r0_write = 1'b0; end
      end
      if (r1_ack) begin
        a1_q.push_back(k); ord_q.push_back(1);
        ack_rdata_c = r1_rdata;
        if (drop1) begin r1_read = 1'b0; r1_write = 1'b0; end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
    stall_force = 1'b0; mm_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'b0010, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'h11,        4'b0010, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'h0,         4'b0110, 1'b1, 1'b0, 32'h0000_0011};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'hA5,        4'b0010, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'hFFFFFFFF,  4'b1010, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'b0001, 1'b1, 1'b0, 32'h0000_00A5};
    vt[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_1008, 32'h12345678,  4'b0010, 1'b0, 1'b1, 32'hDEADBEEF};
    vt[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_1008, 32'h0,         4'b0010, 1'b1, 1'b0, 32'h12345678};

    r0_addr = 32'h0; r0_wdata = 32'h0; r0_sign_mask = 4'h0;
    r1_addr = 32'h0; r1_wdata = 32'h0; r1_sign_mask = 4'h0;
    drop0 = 1'b1; drop1 = 1'b1;

    // Reset state: outputs cleared, r0_stall follows the request combinationally.
    rst_n = 1'b0; r0_read = 1'b0; r0_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
    stall_force = 1'b0; mm_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_memread", mem_memread, 1'b0);
    chk("rst_memwrite", mem_memwrite, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_acks_err", {r0_ack, r1_ack, err}, 3'b000);
    chk("rst_rdata", r0_rdata | r1_rdata, 32'h0);
    chk("rst_stall_idle", r0_stall, 1'b0);
    r0_read = 1'b1;
    #1;
    chk("rst_stall_req", r0_stall, 1'b1);
    do_reset();

    // Single transactions from the table.
    for (int i = 0; i < 8; i++) begin
      if (vt[i].port == REQ_CPU) begin
        r0_read = vt[i].rd; r0_write = vt[i].wr; r0_addr = vt[i].addr;
        r0_wdata = vt[i].wdata; r0_sign_mask = vt[i].mask;
      end else begin
        r1_read = vt[i].rd; r1_write = vt[i].wr; r1_addr = vt[i].addr;
        r1_wdata = vt[i].wdata; r1_sign_mask = vt[i].mask;
      end
      run_log(8);
      chk($sformatf("v%0d_ncmd", i), cmd_q.size(), 1);
      chk($sformatf("v%0d_cmd_cyc", i), q0(cmd_q), 1);
      chk($sformatf("v%0d_cmd_rd", i), cmd_rd_c, vt[i].exp_rd);
      chk($sformatf("v%0d_cmd_wr", i), cmd_wr_c, vt[i].exp_wr);
      chk($sformatf("v%0d_addr", i), cmd_addr_c, vt[i].addr);
      chk($sformatf("v%0d_mask", i), cmd_mask_c, vt[i].mask);
      if (vt[i].exp_wr) chk($sformatf("v%0d_wdata", i), cmd_wdata_c, vt[i].wdata);
      if (vt[i].port == REQ_CPU) begin
        chk($sformatf("v%0d_ack_cyc", i), q0(a0_q), 5);
        chk($sformatf("v%0d_other_ack", i), a1_q.size(), 0);
        chk($sformatf("v%0d_stall_at_ack", i), stall_at_ack_c, 1'b1);
      end else begin
        chk($sformatf("v%0d_ack_cyc", i), q0(a1_q), 5);
        chk($sformatf("v%0d_other_ack", i), a0_q.size(), 0);
      end
      chk($sformatf("v%0d_rdata", i), ack_rdata_c, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), err_q.size(), 0);
    end
    chk("idle_stall_low", r0_stall, 1'b0);

    // Simultaneous requests from reset: CPU first, debug six cycles later.
    do_reset();
    r0_write = 1'b1; r0_addr = 32'h1004; r0_wdata = 32'h11; r0_sign_mask = 4'b0010;
    r1_read = 1'b1; r1_addr = 32'h1008; r1_sign_mask = 4'b0010;
    run_log(16);
    chk("sim_cpu_ack", q0(a0_q), 5);
    chk("sim_dbg_ack", q0(a1_q), 11);
    chk("sim_ncmd", cmd_q.size(), 2);
    if (cmd_q.size() == 2) chk("sim_cmd_gap", cmd_q[1] - cmd_q[0], 6);
    chk("sim_dbg_rdata", r1_rdata, 32'h12345678);

    // Burst fairness: both ports held continuously.
    do_reset();
    drop0 = 1'b0; drop1 = 1'b0;
    r0_read = 1'b1; r0_addr = 32'h1000;
    r1_read = 1'b1; r1_addr = 32'h1008;
    run_log(60);
    chk("fair_nack", ord_q.size(), 10);
    for (int i = 0; i < ord_q.size(); i++)
      chk($sformatf("fair_order%0d", i), ord_q[i], ((i % 5) == 4) ? 1 : 0);
    r0_read = 1'b0; r1_read = 1'b0;
    drop0 = 1'b1; drop1 = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);

    // Timeout: memory never raises clk_stall.
    do_reset();
    r0_read = 1'b1; r0_addr = 32'h1000;
    run_log(8);
    chk("to_pre_rdata", ack_rdata_c, 32'hDEADBEEF);
    mm_en = 1'b0;
    r0_read = 1'b1; r0_addr = 32'h1004;
    run_log(22);
    chk("to_ack_cyc", q0(a0_q), 18);
    chk("to_err_cyc", q0(err_q), 18);
    chk("to_nerr", err_q.size(), 1);
    chk("to_rdata_held", r0_rdata, 32'hDEADBEEF);
    mm_en = 1'b1;
    r0_read = 1'b1; r0_addr = 32'h1004;
    run_log(8);
    chk("to_next_ack", q0(a0_q), 5);
    chk("to_next_err", err_q.size(), 0);
    chk("to_next_rdata", ack_rdata_c, 32'h11);

    // Reset during WAIT_LO while the memory is still stalling.
    do_reset();
    r0_read = 1'b1; r0_addr = 32'h1008;
    run_log(3);
    chk("mid_noack_pre", a0_q.size(), 0);
    rst_n = 1'b0; stall_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_cmd", {mem_memread, mem_memwrite}, 2'b00);
    chk("mid_addr", mem_addr, 32'h0);
    chk("mid_wdata_mask", {mem_write_data, mem_sign_mask}, 36'h0);
    chk("mid_ack", {r0_ack, r1_ack, err}, 3'b000);
    rst_n = 1'b1;
    run_log(6);
    chk("mid_hold_ncmd", cmd_q.size(), 0);
    chk("mid_hold_nack", a0_q.size(), 0);
    chk("mid_hold_stall", r0_stall, 1'b1);
    stall_force = 1'b0;
    run_log(8);
    chk("mid_after_cmd", q0(cmd_q), 1);
    chk("mid_after_ack", q0(a0_q), 5);
    chk("mid_after_rdata", ack_rdata_c, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
